multi_latch_reg: RTL
====================

Name: multi_latch_reg

Overview:
- Parametrised successor of the 12-bit hold/latch bus register for the PDP-8 datapath.
- Replaces the single hold stage with a DEPTH-entry capture queue.
- Adds in-place register operations (clear, increment with carry, complement) and NOUT independently enabled tri-state bus drivers.
- Used for AC/PC/MQ-style registers that drive several internal buses.

Parameters:
WIDTH, 12, data word width in bits (>=2)
DEPTH, 2, capture queue entries (>=1)
NOUT, 2, number of tri-state output ports (>=1)
RESET_VAL, 0, value loaded into the data register on reset

Ports:
CLK  input  1  system clock; all state updates on rising edge
RESET_N  input  1  asynchronous, active-low reset
in  input  WIDTH  capture data
push  input  1  enqueue `in` into the capture queue this cycle
latch  input  1  perform operation `op` on the data register this cycle
op  input  2  operation select: 00 LOAD, 01 CLR, 10 INC, 11 CMP
oe  input  NOUT  per-port output enable
out  output  NOUT*WIDTH  slice k = out[k*WIDTH +: WIDTH]; drives data when oe[k], else high-Z
data_q  output  WIDTH  data register, always driven (debug/ALU tap)
carry  output  1  carry out of the most recent INC
count  output  clog2(DEPTH+1)  queue occupancy
full  output  1  count == DEPTH
empty  output  1  count == 0
ovf  output  1  sticky: push dropped because the queue was full
unf  output  1  sticky: LOAD attempted with nothing to load

Behaviour:
- Reset (RESET_N low, asynchronous, takes effect immediately regardless of CLK):
  - data = RESET_VAL; carry = 0; queue emptied (count = 0, empty = 1, full = 0); ovf = unf = 0.
  - Reset asserted mid-operation discards all queued entries.
- First rising edge after RESET_N deasserts behaves as a normal cycle.
- Queue: FIFO with circular read/write pointers that wrap at DEPTH.
  - push with full and no LOAD pop in the same cycle: word dropped, ovf set, count unchanged.
- latch high, op = LOAD:
  - Queue not empty: data <= oldest entry (pop), count decrements, visible next cycle (1-cycle latency, push to data >= 1 cycle).
  - Queue empty and push: bypass, data <= in; queue stays empty, count stays 0.
  - Queue empty and no push: data unchanged, unf set.
  - Queue full, push and pop together: both succeed, count stays DEPTH, ovf not set.
  - Any other push and pop together: count unchanged, FIFO order preserved.
- latch high, op = CLR: data <= 0, carry <= 0.
- latch high, op = INC: {carry, data} <= data + 1 (WIDTH+1-bit sum); all-ones wraps to 0 with carry = 1, otherwise carry = 0.
- latch high, op = CMP: data <= ~data; carry unchanged.
- latch high, op LOAD/CMP: carry unchanged.
- latch low: data and carry hold; queue still accepts pushes.
- Ops other than LOAD never pop the queue; push in the same cycle enqueues normally.
- Tri-state outputs:
  - Combinational from oe and the registered data.
  - Several oe bits may be active at once; each drives the same value.
  - Bus contention with other drivers is the system's concern, not this block's.
- ovf/unf clear only on reset.
- full/empty/count are registered and consistent with each other every cycle.

Decomposition:
- Package multi_latch_pkg holds:
  - op encodings OP_LOAD = 2'b00, OP_CLR = 2'b01, OP_INC = 2'b10, OP_CMP = 2'b11;
  - a typedef for the 2-bit op.
- One sub-module, latch_fifo, contains:
  - storage, pointers, count, full/empty, ovf;
  - parameters WIDTH and DEPTH;
  - push/pop/bypass handling.
- Top level contains the data register, op decode, carry, unf and the NOUT tri-state drivers, generated per port.

Test Plan:
- Reset/defaults: RESET_N low mid-cycle with 2 words queued -> immediately data = 0, count = 0, empty = 1, ovf = unf = 0, out all Z with oe = 00.
- FIFO order/full: push 12'o1234, then 12'o4321 (DEPTH = 2) -> full = 1. Push 12'o7777 -> ovf = 1, count stays 2. LOAD twice -> data = 12'o1234 then 12'o4321, empty = 1.
- Bypass/underflow:
  - Empty queue, push 12'o0055 with latch/LOAD -> data = 12'o0055, count = 0.
  - Next cycle, LOAD with no push -> data unchanged, unf = 1.
- Full push+pop: full queue [A, B], push C with LOAD -> data = A, count = 2, ovf = 0; then two LOADs -> B, C.
- INC/CLR/CMP:
  - data = 12'o7777, INC -> data = 0, carry = 1; INC -> 12'o0001, carry = 0.
  - CMP -> 12'o7776, carry unchanged.
  - CLR -> 0, carry = 0.
- Outputs: data = 12'o5252, oe = 01 -> out[11:0] = 12'o5252, out[23:12] = Z; oe = 11 -> both slices 12'o5252; data_q always 12'o5252.

Source files
------------

// File: rtl/multi_latch_pkg.sv
// Shared op encodings for the multi-entry latch register.
package multi_latch_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_CLR  = 2'b01,
    OP_INC  = 2'b10,
    OP_CMP  = 2'b11
  } op_t;

endpackage

// File: rtl/multi_latch_reg_latch_fifo.sv
// Capture queue for multi_latch_reg: circular FIFO with bypass to the data register.
module latch_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic [WIDTH-1:0]             in,
  input  logic                         push,
  input  logic                         load,
  output logic                         load_vld,
  output logic [WIDTH-1:0]             load_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         ovf
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             pop;
  logic             bypass;
  logic             wr;
  logic             drop;
  logic [CW-1:0]    cnt_nxt;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A pop in the same cycle frees the slot, so a push into a full queue still lands.
  always_comb begin
    pop       = load && !empty;
    bypass    = load && empty && push;
    wr        = push && !bypass && (!full || pop);
    drop      = push && full && !pop;
    load_vld  = pop || bypass;
    load_data = pop ? mem[rd_ptr] : in;
    cnt_nxt   = count;
    if (wr && !pop)
      cnt_nxt = count + CW'(1);
    else if (pop && !wr)
      cnt_nxt = count - CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (wr)
      mem[wr_ptr] <= in;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      if (wr)
        wr_ptr <= bump(wr_ptr);
      if (pop)
        rd_ptr <= bump(rd_ptr);
      count <= cnt_nxt;
      full  <= (cnt_nxt == CW'(DEPTH));
      empty <= (cnt_nxt == '0);
      if (drop)
        ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/multi_latch_reg.sv
// Datapath register with capture queue, in-place ops and per-port tri-state bus drivers.
import multi_latch_pkg::*;

module multi_latch_reg #(
  parameter int unsigned     WIDTH     = 12,
  parameter int unsigned     DEPTH     = 2,
  parameter int unsigned     NOUT      = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic [WIDTH-1:0]             in,
  input  logic                         push,
  input  logic                         latch,
  input  logic [1:0]                   op,
  input  logic [NOUT-1:0]              oe,
  output logic [NOUT*WIDTH-1:0]        out,
  output logic [WIDTH-1:0]             data_q,
  output logic                         carry,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         ovf,
  output logic                         unf
);

  op_t              op_e;
  logic             is_load;
  logic             load_vld;
  logic [WIDTH-1:0] load_data;

  assign op_e    = op_t'(op);
  assign is_load = latch && (op_e == OP_LOAD);

  latch_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .in        (in),
    .push      (push),
    .load      (is_load),
    .load_vld  (load_vld),
    .load_data (load_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      data_q <= RESET_VAL;
      carry  <= 1'b0;
      unf    <= 1'b0;
    end else if (latch) begin
      unique case (op_e)
        OP_LOAD: begin
          if (load_vld)
            data_q <= load_data;
          else
            unf <= 1'b1;
        end
        OP_CLR: begin
          data_q <= '0;
          carry  <= 1'b0;
        end
        OP_INC: {carry, data_q} <= {1'b0, data_q} + (WIDTH + 1)'(1);
        OP_CMP: data_q <= ~data_q;
      endcase
    end
  end

  for (genvar k = 0; k < NOUT; k++) begin : g_drv
    assign out[k*WIDTH +: WIDTH] = oe[k] ? data_q : 'z;
  end

endmodule
